noise_filter: RTL

//  Moving-average denoiser for 24-bit unsigned waveform samples; the receive-side

---
 rtl/noise_filter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/noise_filter.sv
// rtl/noise_filter.sv - moving-average denoiser over 2^win_sel samples with a circular window buffer
module noise_filter #(
    parameter int DATA_W       = 24,
    parameter int LOG2_MAX_WIN = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              filter_enable,
    input  logic [2:0]        win_sel,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] input_wave,
    output logic              out_valid,
    output logic [DATA_W-1:0] output_wave,
    output logic              warm
);

    localparam int DEPTH = 1 << LOG2_MAX_WIN;
    localparam int PTR_W = LOG2_MAX_WIN;
    localparam int CNT_W = LOG2_MAX_WIN + 1;
    localparam int SUM_W = DATA_W + LOG2_MAX_WIN;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BYPASS = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr, ptr_d;
    logic [2:0]         k_reg, k_eff;
    logic [DATA_W-1:0]  out_d;
    logic               valid_d;
    logic               warm_d;
    logic               buf_we;

    logic [DATA_W-1:0]  win_buf [DEPTH];

    logic               win_change;
    logic [CNT_W-1:0]   win_n;
    logic [SUM_W-1:0]   base_sum;
    logic [CNT_W-1:0]   base_count;
    logic               full;
    logic [PTR_W-1:0]   old_idx;
    logic [DATA_W-1:0]  x_old;
    logic [SUM_W-1:0]   acc_sum;
    logic [CNT_W-1:0]   acc_count;
    logic [DATA_W-1:0]  avg;

    always_comb begin
        k_eff = win_sel;
        if (win_sel > 3'(LOG2_MAX_WIN)) begin
            k_eff = 3'(LOG2_MAX_WIN);
        end
    end

    // A new window size, or leaving bypass, restarts the average from an empty window;
    // a sample accepted in that cycle becomes the first of the new window.
    always_comb begin
        win_n      = CNT_W'(1) << k_eff;
        win_change = (k_eff != k_reg);
        base_sum   = sum_q;
        base_count = count_q;
        if (win_change || state_q == ST_BYPASS) begin
            base_sum   = '0;
            base_count = '0;
        end
        full      = (base_count == win_n);
        old_idx   = wr_ptr - win_n[PTR_W-1:0];
        x_old     = full ? win_buf[old_idx] : '0;
        acc_sum   = base_sum + SUM_W'(input_wave) - SUM_W'(x_old);
        acc_count = full ? base_count : base_count + CNT_W'(1);
        avg       = DATA_W'(acc_sum >> k_eff);
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        ptr_d   = wr_ptr;
        buf_we  = 1'b0;
        out_d   = output_wave;
        valid_d = 1'b0;
        if (!filter_enable) begin
            // Buffer contents need no clearing: the zero count masks every stale entry.
            state_d = ST_BYPASS;
            sum_d   = '0;
            count_d = '0;
            if (in_valid) begin
                valid_d = 1'b1;
                out_d   = input_wave;
            end
        end else if (in_valid) begin
            sum_d   = acc_sum;
            count_d = acc_count;
            ptr_d   = wr_ptr + PTR_W'(1);
            buf_we  = 1'b1;
            out_d   = avg;
            valid_d = 1'b1;
            state_d = (acc_count == win_n) ? ST_RUN : ST_FILL;
        end else begin
            sum_d   = base_sum;
            count_d = base_count;
            state_d = (base_count == win_n) ? ST_RUN : ST_FILL;
        end
        warm_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_FILL;
            sum_q       <= '0;
            count_q     <= '0;
            wr_ptr      <= '0;
            k_reg       <= '0;
            output_wave <= '0;
            out_valid   <= 1'b0;
            warm        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            wr_ptr      <= ptr_d;
            k_reg       <= k_eff;
            output_wave <= out_d;
            out_valid   <= valid_d;
            warm        <= warm_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            win_buf[wr_ptr] <= input_wave;
        end
    end

endmodule
